cr_quantizer: RTL and testbench

CR_QUANTIZER -- requirements
Module: cr_quantizer

---
 rtl/cr_quantizer.sv | 158 +++++++++++++++
 tb/tb_cr_quantizer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_quantizer.sv
// Cr-channel JPEG quantizer: captures a 64-coefficient DCT block and streams
// quantized coefficients in raster order. Define CR_QUANT_ROUND_EN for round-to-nearest, else floor.
module cr_quantizer (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [703:0]        z_in,
    output logic                busy,
    output logic                q_valid,
    output logic signed [10:0]  q_out,
    output logic [5:0]          q_index,
    output logic                block_done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [5:0]         cnt;
    logic [10:0]        coef_buf [64];

    // Issue stage (buffer read), multiply stage, output stage
    logic               v_s0;
    logic signed [10:0] z_s0;
    logic [12:0]        r_s0;
    logic [5:0]         k_s0;

    logic               v_s1;
    logic signed [24:0] p_s1;
    logic [5:0]         k_s1;

    logic signed [24:0] z_ext;
    logic signed [24:0] r_ext;
    logic signed [24:0] prod;
    logic signed [24:0] p_adj;

    // round(4096 / Qc[k]) for the JPEG chroma table; every unlisted entry is Q=99
    function automatic logic [12:0] recip_of(input logic [5:0] k);
        logic [2:0] row;
        logic [2:0] col;
        row      = k[5:3];
        col      = k[2:0];
        recip_of = 13'd41;
        case (row)
            3'd0: case (col)
                3'd0: recip_of = 13'd241;
                3'd1: recip_of = 13'd228;
                3'd2: recip_of = 13'd171;
                3'd3: recip_of = 13'd87;
                default: recip_of = 13'd41;
            endcase
            3'd1: case (col)
                3'd0: recip_of = 13'd228;
                3'd1: recip_of = 13'd195;
                3'd2: recip_of = 13'd158;
                3'd3: recip_of = 13'd62;
                default: recip_of = 13'd41;
            endcase
            3'd2: case (col)
                3'd0: recip_of = 13'd171;
                3'd1: recip_of = 13'd158;
                3'd2: recip_of = 13'd73;
                default: recip_of = 13'd41;
            endcase
            3'd3: case (col)
                3'd0: recip_of = 13'd87;
                3'd1: recip_of = 13'd62;
                default: recip_of = 13'd41;
            endcase
            default: recip_of = 13'd41;
        endcase
    endfunction

    // NOTE: the coefficient buffer has no reset; it is always written in full before it is read.
    always_ff @(posedge clk) begin
        if (state == IDLE && enable) begin
            for (int k = 0; k < 64; k++) begin
                coef_buf[k] <= z_in[11*k +: 11];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            v_s0  <= 1'b0;
            z_s0  <= '0;
            r_s0  <= '0;
            k_s0  <= '0;
        end else begin
            v_s0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    z_s0 <= coef_buf[cnt];
                    r_s0 <= recip_of(cnt);
                    k_s0 <= cnt;
                    v_s0 <= 1'b1;
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last coefficient leaves the output register this cycle
                    if (block_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign z_ext = {{14{z_s0[10]}}, z_s0};
    assign r_ext = {12'd0, r_s0};
    assign prod  = z_ext * r_ext;

`ifdef CR_QUANT_ROUND_EN
    assign p_adj = p_s1 + 25'sd2048;
`else
    assign p_adj = p_s1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_s1       <= 1'b0;
            p_s1       <= '0;
            k_s1       <= '0;
            q_valid    <= 1'b0;
            q_out      <= '0;
            q_index    <= '0;
            block_done <= 1'b0;
        end else begin
            v_s1 <= v_s0;
            if (v_s0) begin
                p_s1 <= prod;
                k_s1 <= k_s0;
            end
            q_valid    <= v_s1;
            block_done <= v_s1 && (k_s1 == 6'd63);
            if (v_s1) begin
                // Bits [22:12] are the arithmetic shift by 12 truncated to 11 bits
                q_out   <= p_adj[22:12];
                q_index <= k_s1;
            end
        end
    end

endmodule

// File: tb/tb_cr_quantizer.sv
// Scoreboard bench for cr_quantizer: stimulus pushes expected outputs computed
// from the chroma table with plain arithmetic; a negedge monitor pops and compares.
module tb_cr_quantizer;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [703:0]       z_in;
    logic               busy;
    logic               q_valid;
    logic signed [10:0] q_out;
    logic [5:0]         q_index;
    logic               block_done;

    cr_quantizer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .z_in       (z_in),
        .busy       (busy),
        .q_valid    (q_valid),
        .q_out      (q_out),
        .q_index    (q_index),
        .block_done (block_done)
    );

    typedef struct {
        int cyc;
        int q;
        int idx;
        int done;
    } exp_t;

    localparam int QC [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };

    exp_t sb [$];
    int   blk [64];
    int   checks;
    int   errors;
    int   cyc;
    int   cap;
    bit   cap_valid;
    bit   accepted;
    int   last_q;
    int   last_idx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int floor_div4096(input int p);
        if (p >= 0) return p / 4096;
        return -((-p + 4095) / 4096);
    endfunction

    function automatic int model_q(input int z, input int k);
        int recip;
        int p;
        recip = (8192 + QC[k]) / (2 * QC[k]);
        p     = z * recip;
`ifdef CR_QUANT_ROUND_EN
        p     = p + 2048;
`endif
        return floor_div4096(p);
    endfunction

    function automatic bit exp_busy();
        return cap_valid && (cyc >= cap) && (cyc < cap + 67);
    endfunction

    // Drive one enable pulse from a negedge; a block starting at capture
    // edge N produces outputs at N+3..N+66 and holds busy until edge N+67.
    task automatic launch();
        int n;
        exp_t e;
        for (int k = 0; k < 64; k++) z_in[11*k +: 11] = 11'(blk[k]);
        enable = 1'b1;
        n = cyc + 1;
        accepted = !(cap_valid && (n < cap + 68));
        if (accepted) begin
            cap = n;
            cap_valid = 1'b1;
            for (int k = 0; k < 64; k++) begin
                e.cyc  = n + 3 + k;
                e.q    = model_q(blk[k], k);
                e.idx  = k;
                e.done = (k == 63) ? 1 : 0;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic fill_zero();
        for (int k = 0; k < 64; k++) blk[k] = 0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(0, 2047)) - 1024;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            check("busy", int'(busy), int'(exp_busy()));
            if (q_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_q_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("q_valid_cycle", cyc, e.cyc);
                    check("q_out", int'(q_out), e.q);
                    check("q_index", int'(q_index), e.idx);
                    check("block_done", int'(block_done), e.done);
                end
                last_q   = int'(q_out);
                last_idx = int'(q_index);
            end else begin
                check("hold_q_out", int'(q_out), last_q);
                check("hold_q_index", int'(q_index), last_idx);
                check("idle_block_done", int'(block_done), 0);
            end
        end
    end

    initial begin
        int n1;
        bit found;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        cap       = 0;
        cap_valid = 1'b0;
        last_q    = 0;
        last_idx  = 0;
        rst       = 1'b0;
        enable    = 1'b0;
        z_in      = '0;

        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_q_valid", int'(q_valid), 0);
        check("rst_block_done", int'(block_done), 0);
        check("rst_q_out", int'(q_out), 0);
        check("rst_q_index", int'(q_index), 0);

        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero block
        fill_zero();
        launch();
        wait_until(cap + 70);

        // Directed boundary values
        fill_zero();
        blk[0] = 340; blk[63] = 99;
        launch();
        wait_until(cap + 70);
        fill_zero();
        blk[0] = -340;
        launch();
        wait_until(cap + 70);
        fill_zero();
        blk[0] = -1024; blk[1] = 1023; blk[9] = -1024; blk[63] = -1024;
        launch();
        wait_until(cap + 70);

        // Enable mid-block ignored, then back-to-back block right after busy drops
        fill_random();
        launch();
        n1 = cap;
        wait_until(n1 + 10);
        fill_random();
        launch();
        check("mid_block_enable_ignored", int'(accepted), 0);
        wait_until(n1 + 67);
        fill_random();
        launch();
        check("back_to_back_capture", cap, n1 + 68);
        wait_until(cap + 70);

        // Random blocks with varied idle gaps
        for (int b = 0; b < 4; b++) begin
            fill_random();
            launch();
            wait_until(cap + 67 + int'($urandom_range(0, 4)));
        end

        // Asynchronous reset mid-block at q_index 30
        fill_random();
        launch();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (q_valid && q_index == 6'd30) found = 1'b1;
        end
        check("reached_index_30", int'(found), 1);
        #2 rst = 1'b0;
        #1;
        sb.delete();
        cap_valid = 1'b0;
        last_q    = 0;
        last_idx  = 0;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_q_valid", int'(q_valid), 0);
        check("async_rst_block_done", int'(block_done), 0);
        check("async_rst_q_out", int'(q_out), 0);
        check("async_rst_q_index", int'(q_index), 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (6) @(negedge clk);
        fill_random();
        launch();
        wait_until(cap + 70);

        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
